// File: rtl/keycode_action_gen.sv
// Per-key action pulse generator: maps a packed multi-slot keycode word onto N
// channels, each with delayed auto-repeat or toggle behaviour, all timed in ticks.
module keycode_action_gen #(
  parameter int                 NUM_KEYS    = 8,
  parameter int                 KEY_SLOTS   = 2,
  parameter int                 DAS_DELAY   = 16,
  parameter int                 ARR_PERIOD  = 4,
  parameter logic [NUM_KEYS-1:0] TOGGLE_MASK = '0
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    tick,
  input  logic [8*KEY_SLOTS-1:0]  keycode,
  input  logic [8*NUM_KEYS-1:0]   key_map,
  output logic [NUM_KEYS-1:0]     step,
  output logic [NUM_KEYS-1:0]     held,
  output logic [NUM_KEYS-1:0]     toggle_state
);

  localparam int CNT_TOP = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
  localparam int CW      = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] DAS_C   = CW'(DAS_DELAY);
  localparam logic [CW-1:0] ARR_C   = CW'(ARR_PERIOD);
  localparam logic [CW-1:0] CNT_SAT = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    WAIT_REL,
    IDLE,
    DELAY,
    REPEAT
  } state_t;

  state_t          state [NUM_KEYS];
  logic [CW-1:0]   cnt   [NUM_KEYS];
  logic [NUM_KEYS-1:0] down;

  always_comb begin
    // NOTE: default every bit before the loop so no path leaves down unassigned (no latch).
    down = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      for (int j = 0; j < KEY_SLOTS; j++) begin
        if (key_map[8*i +: 8] != 8'h00 && keycode[8*j +: 8] == key_map[8*i +: 8])
          down[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking default clear makes step a single-cycle pulse; later assignments win.
    step <= '0;
    if (Reset) begin
      held         <= '0;
      toggle_state <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state[i] <= WAIT_REL;
        cnt[i]   <= '0;
      end
    end else if (tick) begin
      held <= down;
      for (int i = 0; i < NUM_KEYS; i++) begin
        case (state[i])
          // Key held through reset must be released before it can act again.
          WAIT_REL: if (!down[i]) state[i] <= IDLE;
          IDLE: begin
            if (down[i]) begin
              step[i]  <= 1'b1;
              state[i] <= DELAY;
              cnt[i]   <= CNT_ONE;
              if (TOGGLE_MASK[i]) toggle_state[i] <= ~toggle_state[i];
            end
          end
          DELAY: begin
            if (!down[i]) begin
              state[i] <= IDLE;
            end else if (!TOGGLE_MASK[i] && ARR_PERIOD != 0 && cnt[i] == DAS_C) begin
              step[i]  <= 1'b1;
              state[i] <= REPEAT;
              cnt[i]   <= CNT_ONE;
            end else if (cnt[i] != CNT_SAT) begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          REPEAT: begin
            if (!down[i]) begin
              state[i] <= IDLE;
            end else if (cnt[i] == ARR_C) begin
              step[i] <= 1'b1;
              cnt[i]  <= CNT_ONE;
            end else if (cnt[i] != CNT_SAT) begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          default: state[i] <= WAIT_REL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keycode_action_gen.sv
// Scoreboard bench for keycode_action_gen: a repeating build and an ARR_PERIOD=0
// build share stimulus; an age-based reference model predicts every tick's outputs.
module tb_keycode_action_gen;

  localparam int          NK    = 8;
  localparam int          NS    = 2;
  localparam int          DAS   = 16;
  localparam int          ARR   = 4;
  localparam logic [7:0]  TMASK = 8'h08;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              tick = 1'b0;
  logic [8*NS-1:0]   keycode = '0;
  logic [8*NK-1:0]   key_map = '0;
  logic [NK-1:0]     step_a, held_a, tog_a;
  logic [NK-1:0]     step_b, held_b, tog_b;

  keycode_action_gen #(
    .NUM_KEYS(NK), .KEY_SLOTS(NS), .DAS_DELAY(DAS), .ARR_PERIOD(ARR), .TOGGLE_MASK(TMASK)
  ) dut_a (
    .Clk(Clk), .Reset(Reset), .tick(tick), .keycode(keycode), .key_map(key_map),
    .step(step_a), .held(held_a), .toggle_state(tog_a)
  );

  keycode_action_gen #(
    .NUM_KEYS(NK), .KEY_SLOTS(NS), .DAS_DELAY(DAS), .ARR_PERIOD(0), .TOGGLE_MASK(TMASK)
  ) dut_b (
    .Clk(Clk), .Reset(Reset), .tick(tick), .keycode(keycode), .key_map(key_map),
    .step(step_b), .held(held_b), .toggle_state(tog_b)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [NK-1:0] step;
    logic [NK-1:0] held;
    logic [NK-1:0] tog;
  } resp_t;

  typedef struct packed {
    resp_t a;
    resp_t b;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: per channel, "locked" after reset until released, then the
  // number of ticks since the press decides pulses arithmetically.
  bit locked [2][NK];
  int age    [2][NK];
  bit tog_m  [2][NK];

  function automatic bit key_down(int ch, logic [8*NS-1:0] kc, logic [8*NK-1:0] km);
    logic [7:0] code;
    code = km[8*ch +: 8];
    if (code == 8'h00) return 1'b0;
    for (int s = 0; s < NS; s++)
      if (kc[8*s +: 8] == code) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < NK; ch++) begin
        locked[d][ch] = 1'b1;
        age[d][ch]    = -1;
        tog_m[d][ch]  = 1'b0;
      end
  endtask

  task automatic model_tick(input int d, input int arr, output resp_t r);
    bit dn;
    r = '0;
    for (int ch = 0; ch < NK; ch++) begin
      dn = key_down(ch, keycode, key_map);
      r.held[ch] = dn;
      if (locked[d][ch]) begin
        if (!dn) locked[d][ch] = 1'b0;
      end else if (!dn) begin
        age[d][ch] = -1;
      end else if (age[d][ch] < 0) begin
        age[d][ch] = 0;
        r.step[ch] = 1'b1;
        if (TMASK[ch]) tog_m[d][ch] = ~tog_m[d][ch];
      end else begin
        age[d][ch]++;
        if (!TMASK[ch] && arr != 0 && age[d][ch] >= DAS && ((age[d][ch] - DAS) % arr) == 0)
          r.step[ch] = 1'b1;
      end
      r.tog[ch] = tog_m[d][ch];
    end
  endtask

  task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Driver: one Clk cycle; keycode is scrambled on cycles the DUT must ignore.
  task automatic cycle(input bit t, input bit rst, input logic [8*NS-1:0] kc);
    resp_t ra, rb;
    @(posedge Clk);
    #1;
    tick  = t;
    Reset = rst;
    if (t) keycode = kc;
    else   keycode = 16'($urandom);
    if (rst) begin
      model_reset();
      sb_q.push_back('0);
    end else if (t) begin
      model_tick(0, ARR, ra);
      model_tick(1, 0, rb);
      sb_q.push_back({ra, rb});
    end
  endtask

  task automatic run_ticks(input int n, input logic [8*NS-1:0] kc, input int gap = 4);
    for (int k = 0; k < n; k++) begin
      cycle(1'b1, 1'b0, kc);
      for (int g = 1; g < gap; g++) cycle(1'b0, 1'b0, kc);
    end
  endtask

  // Monitor: pops one expectation for every cycle following tick/Reset; in
  // between, step must stay low and held/toggle_state must not move.
  bit   flag = 1'b0;
  bit   mon_on = 1'b0;
  exp_t last_exp = '0;
  int   p0_a = 0, p0_b = 0, p3_a = 0;
  logic any2 = 1'b0;

  always @(posedge Clk) flag <= tick | Reset;

  always @(negedge Clk) begin
    exp_t e;
    if (flag) begin
      if (sb_q.size() == 0) begin
        check_int("sb_underflow", 0, 1);
      end else begin
        e = sb_q.pop_front();
        check("step_a", step_a, e.a.step);
        check("held_a", held_a, e.a.held);
        check("tog_a",  tog_a,  e.a.tog);
        check("step_b", step_b, e.b.step);
        check("held_b", held_b, e.b.held);
        check("tog_b",  tog_b,  e.b.tog);
        last_exp = e;
        mon_on   = 1'b1;
      end
    end else if (mon_on) begin
      check("idle_step_a", step_a, '0);
      check("idle_step_b", step_b, '0);
      check("idle_held_a", held_a, last_exp.a.held);
      check("idle_tog_a",  tog_a,  last_exp.a.tog);
    end
    if (mon_on) begin
      if (step_a[0] === 1'b1) p0_a++;
      if (step_b[0] === 1'b1) p0_b++;
      if (step_a[3] === 1'b1) p3_a++;
      any2 = any2 | step_a[2] | step_b[2];
    end
  end

  int n0a, n0b, n3a;

  initial begin
    key_map = {8'h1A, 8'h16, 8'h04, 8'h00, 8'h13, 8'h00, 8'h07, 8'h04};

    // Reset, including a tick coinciding with Reset (Reset wins), then idle ticks.
    cycle(1'b0, 1'b1, 16'h0000);
    cycle(1'b1, 1'b1, 16'h0004);
    run_ticks(3, 16'h0000);

    // Hold A for 30 ticks: pulses at 0,16,20,24,28; the no-repeat build fires once.
    n0a = p0_a; n0b = p0_b;
    run_ticks(30, 16'h0004);
    run_ticks(2, 16'h0000);
    check_int("hold30_pulses_a", p0_a - n0a, 5);
    check_int("hold30_pulses_b", p0_b - n0b, 1);

    // A and D together, then drop slot 0 only; D keeps repeating.
    run_ticks(25, 16'h0704);
    run_ticks(20, 16'h0700);
    run_ticks(2, 16'h0000);

    // Toggle channel: one pulse per press regardless of hold length.
    n3a = p3_a;
    run_ticks(40, 16'h0013);
    run_ticks(2, 16'h0000);
    run_ticks(5, 16'h1300);
    run_ticks(2, 16'h0000);
    check_int("toggle_pulses", p3_a - n3a, 2);

    // Reset mid-DELAY while A stays down: locked until released and re-pressed.
    run_ticks(5, 16'h0004);
    cycle(1'b0, 1'b1, 16'h0004);
    n0a = p0_a;
    run_ticks(20, 16'h0004);
    check_int("locked_no_pulse", p0_a - n0a, 0);
    run_ticks(1, 16'h0000);
    run_ticks(3, 16'h0004);
    check_int("repress_pulse", p0_a - n0a, 1);

    // Remap channel 0 while held, then restore: release seen, then a fresh press.
    key_map[7:0] = 8'h05;
    run_ticks(3, 16'h0004);
    key_map[7:0] = 8'h04;
    run_ticks(3, 16'h0004);
    run_ticks(2, 16'h0000);

    // Long hold with back-to-back ticks; the no-repeat build fires exactly once.
    n0b = p0_b;
    run_ticks(100, 16'h0004, 2);
    run_ticks(2, 16'h0000);
    check_int("arr0_single_pulse", p0_b - n0b, 1);

    // Randomized traffic with random tick spacing and occasional resets.
    for (int k = 0; k < 300; k++) begin
      logic [7:0] codes [7];
      logic [7:0] s0, s1;
      codes = '{8'h00, 8'h04, 8'h07, 8'h13, 8'h16, 8'h1A, 8'h2C};
      s0 = codes[$urandom_range(6)];
      s1 = codes[$urandom_range(6)];
      if ($urandom_range(49) == 0) cycle(1'b0, 1'b1, {s1, s0});
      run_ticks(1, {s1, s0}, $urandom_range(1, 5));
    end

    repeat (4) cycle(1'b0, 1'b0, 16'h0000);
    check_int("sb_drained", sb_q.size(), 0);
    check("ch2_never_fires", {7'b0, any2}, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keycode_action_gen.md
# keycode_action_gen

Parametrised per-key action generator between the USB keycode export (Nios `keycode` PIO) and the game logic (square movers, pause/restart, rotation). It turns a multi-slot keycode word into one action pulse per press, with delayed auto-repeat (DAS/ARR) or toggle behaviour per channel. It generalises the fixed four-key step state machine to N mappable keys, multiple simultaneous keycode slots, frame-rate-independent clocking via a tick enable, and a power-up/reset release lockout.

## Interface
Parameters:
- NUM_KEYS, 8, number of action channels
- KEY_SLOTS, 2, number of 8-bit keycodes packed in `keycode`
- DAS_DELAY, 16, ticks from first pulse to first repeat pulse; 1..255
- ARR_PERIOD, 4, ticks between repeat pulses; 0 disables repeat on all channels
- TOGGLE_MASK, 8'h00, bit i set makes channel i a toggle channel (no repeat)

Ports:
- Clk  in  1  system clock; only clock in the block
- Reset  in  1  synchronous, active-high reset
- tick  in  1  one-Clk-cycle frame enable (e.g. vsync edge); all timing counted in ticks
- keycode  in  8*KEY_SLOTS  slot j = keycode[8j+7:8j]; 8'h00 = empty slot
- key_map  in  8*NUM_KEYS  channel i code = key_map[8i+7:8i]; 8'h00 disables channel
- step  out  NUM_KEYS  one-Clk-cycle action pulse per channel
- held  out  NUM_KEYS  registered "key currently down" per channel
- toggle_state  out  NUM_KEYS  toggle flag per channel; always 0 on non-toggle channels

## Operation
- Match: `down_i` = (key_map_i != 0) AND any slot j has keycode_j == key_map_i. Evaluated combinationally, sampled only on tick cycles.
- Per-channel FSM, states WAIT_REL, IDLE, DELAY, REPEAT; transitions only on tick cycles:
  - WAIT_REL: !down_i -> IDLE; down_i stays, no pulse.
  - IDLE: down_i -> pulse; toggle channel -> flip toggle_state, go DELAY-equivalent hold (stays DELAY, never leaves to REPEAT); non-toggle -> DELAY, cnt=1.
  - DELAY: !down_i -> IDLE. Else if non-toggle, ARR_PERIOD!=0 and cnt==DAS_DELAY -> pulse, REPEAT, cnt=1; else cnt++ (saturating).
  - REPEAT: !down_i -> IDLE. Else if cnt==ARR_PERIOD -> pulse, cnt=1; else cnt++.
- Counter width clog2(max(DAS_DELAY,ARR_PERIOD)+1) per channel; saturates, never wraps.
- Channels independent: simultaneous presses on different channels produce simultaneous pulses; two channels mapped to same code both fire.
- key_map change while held: channel sees !down_i at next tick, returns to IDLE.

## Timing
- Reset (sync, priority over tick): all FSMs -> WAIT_REL, counters 0, step=0, held=0, toggle_state=0 on the cycle after Reset is sampled high.
- Reset mid-hold: key still down after reset release gives no pulse until released and re-pressed (no spurious pause/restart).
- step is registered: asserted exactly the Clk cycle after the tick on which its condition holds; width one Clk cycle; never asserted on non-tick-following cycles.
- held updates on the cycle after each tick (registered down_i); does not change between ticks.
- Pulse schedule for a key held from tick k (non-toggle): ticks k, k+DAS_DELAY, k+DAS_DELAY+ARR_PERIOD, ...
- Release and re-press on consecutive ticks: release tick -> IDLE, next tick -> pulse (min re-press interval 2 ticks).
- tick and Reset in the same cycle: Reset wins; tick is ignored.
- keycode changes between ticks are invisible; glitches shorter than the tick spacing are filtered.

## Test plan
- Defaults, key_map ch0=8'h04 ('A'), ch3=8'h13 toggle (TOGGLE_MASK=8'h08); Reset, release, tick every 4 Clk -> all outputs 0; after ticks with keycode=0, FSMs in IDLE.
- keycode=16'h0004 held 30 ticks from tick 0 -> step[0] after ticks 0,16,20,24,28 only (5 pulses); held[0]=1 from cycle after tick 0.
- keycode=16'h0704 (A and D=ch1 8'h07) same tick -> step[0] and step[1] in the same cycle; release slot 0 only -> ch0 IDLE, ch1 continues repeat schedule.
- Toggle ch3: press 8'h13 for 40 ticks -> exactly one step[3], toggle_state[3] 0->1; release, press again -> toggle_state[3] 1->0.
- Hold 8'h04, assert Reset 1 cycle mid-DELAY -> outputs clear; still held 20 ticks -> no step[0]; release 1 tick, press -> step[0] after that tick.
- ARR_PERIOD=0 build: hold 8'h04 100 ticks -> exactly one step[0]; key_map ch2=8'h00 with keycode=16'h0000 -> step[2] never asserts.
